// File: rtl/half_adder_reg.sv
// half_adder_reg: registered, vectorised half adder.
//
// WIDTH independent 1-bit half-adder lanes (s = x ^ y, c = x & y per lane). There is no
// carry between lanes. Every result and summary output is registered, so latency is one
// cycle and no input reaches an output combinationally.
//
// Optional build macro: HA_STATS_EN adds a saturating 16-bit count of accepted operations
// that produced at least one carry.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active-high; clears every output
//   in_valid       x/y hold an operation to accept this cycle
//   x, y           operands, one bit per lane
//   out_valid      s/c/summary were updated on the last edge
//   s              per-lane sum (x ^ y)
//   c              per-lane carry (x & y)
//   carry_count    number of lanes with c = 1 (0..WIDTH)
//   any_carry      OR-reduction of c
//   stat_carry_ops (HA_STATS_EN only) saturating count of carry-producing operations
module half_adder_reg #(
  parameter int unsigned  WIDTH = 1,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic [CW-1:0]    carry_count,
  output logic             any_carry
`ifdef HA_STATS_EN
  ,
  output logic [15:0]      stat_carry_ops
`endif
);

  // Per-lane combinational results, only ever sampled into registers.
  logic [WIDTH-1:0] sum_vec;
  logic [WIDTH-1:0] carry_vec;
  logic [CW-1:0]    carry_pop;
  logic             carry_any;

  assign sum_vec   = x ^ y;
  assign carry_vec = x & y;
  assign carry_any = |carry_vec;

  always_comb begin
    carry_pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      carry_pop = carry_pop + CW'(carry_vec[i]);
    end
  end

  logic             valid_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] c_q;
  logic [CW-1:0]    count_q;
  logic             any_q;

  // Results only move on an accepted operation, so X on x/y while idle cannot leak through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      s_q     <= '0;
      c_q     <= '0;
      count_q <= '0;
      any_q   <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        s_q     <= sum_vec;
        c_q     <= carry_vec;
        count_q <= carry_pop;
        any_q   <= carry_any;
      end
    end
  end

  assign out_valid   = valid_q;
  assign s           = s_q;
  assign c           = c_q;
  assign carry_count = count_q;
  assign any_carry   = any_q;

`ifdef HA_STATS_EN
  logic [15:0] stat_q;

  // Saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else if (in_valid && carry_any && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_carry_ops = stat_q;
`endif

endmodule

// File: tb/tb_half_adder_reg.sv
module tb_half_adder_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b1;
  logic [0:0] x1 = 1'b1, y1 = 1'b1;
  logic [7:0] x8 = 8'hFF, y8 = 8'hFF;

  logic       v1, v8, a1, a8;
  logic [0:0] s1, c1, n1;
  logic [7:0] s8, c8;
  logic [3:0] n8;
`ifdef HA_STATS_EN
  logic [15:0] st1, st8;
`endif

  always #5 clk = ~clk;

  half_adder_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x1), .y(y1),
    .out_valid(v1), .s(s1), .c(c1), .carry_count(n1), .any_carry(a1)
`ifdef HA_STATS_EN
    , .stat_carry_ops(st1)
`endif
  );

  half_adder_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x8), .y(y8),
    .out_valid(v8), .s(s8), .c(c8), .carry_count(n8), .any_carry(a8)
`ifdef HA_STATS_EN
    , .stat_carry_ops(st8)
`endif
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the last accepted operation's results, plain arithmetic.
  logic       m_v1, m_v8, m_a1, m_a8;
  logic [0:0] m_s1, m_c1;
  logic [7:0] m_s8, m_c8;
  int         m_n1, m_n8;
  int         m_stat1, m_stat8;

  function automatic int ones(input logic [7:0] v, input int w);
    int n = 0;
    for (int i = 0; i < w; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic model_clear();
    m_v1 = 0; m_v8 = 0; m_s1 = 0; m_c1 = 0; m_s8 = 0; m_c8 = 0;
    m_n1 = 0; m_n8 = 0; m_a1 = 0; m_a8 = 0; m_stat1 = 0; m_stat8 = 0;
  endtask

  initial model_clear();

  // Inputs only change at negedge, so sampling them at posedge is race-free.
  always @(posedge clk) begin
    if (!rst) begin
      m_v1 = in_valid;
      m_v8 = in_valid;
      if (in_valid) begin
        m_s1 = x1 ^ y1;  m_c1 = x1 & y1;  m_n1 = ones({7'd0, m_c1}, 1);  m_a1 = (m_n1 > 0);
        m_s8 = x8 ^ y8;  m_c8 = x8 & y8;  m_n8 = ones(m_c8, 8);          m_a8 = (m_n8 > 0);
        if (m_a1 && m_stat1 < 65535) m_stat1++;
        if (m_a8 && m_stat8 < 65535) m_stat8++;
      end
    end
  end

  // One compare process, every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("w1.out_valid", 64'(v1), 64'(m_v1));
    chk("w1.s", 64'(s1), 64'(m_s1));
    chk("w1.c", 64'(c1), 64'(m_c1));
    chk("w1.carry_count", 64'(n1), 64'(m_n1));
    chk("w1.any_carry", 64'(a1), 64'(m_a1));
    chk("w8.out_valid", 64'(v8), 64'(m_v8));
    chk("w8.s", 64'(s8), 64'(m_s8));
    chk("w8.c", 64'(c8), 64'(m_c8));
    chk("w8.carry_count", 64'(n8), 64'(m_n8));
    chk("w8.any_carry", 64'(a8), 64'(m_a8));
`ifdef HA_STATS_EN
    chk("w1.stat", 64'(st1), 64'(m_stat1));
    chk("w8.stat", 64'(st8), 64'(m_stat8));
`endif
  end

  // Drive one cycle's inputs at negedge, then land 1 time unit after the posedge.
  task automatic step(input logic v, input logic [0:0] a1_, input logic [0:0] b1_,
                      input logic [7:0] a8_, input logic [7:0] b8_);
    @(negedge clk);
    in_valid = v; x1 = a1_; y1 = b1_; x8 = a8_; y8 = b8_;
    @(posedge clk);
    #1;
  endtask

  logic [0:0] tt_x [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [0:0] tt_y [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [0:0] tt_s [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [0:0] tt_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // Reset held with live operands and a running clock: outputs stay zero.
    #12;
    chk("rst.s", 64'(s1), 64'd0);
    chk("rst.c", 64'(c1), 64'd0);
    chk("rst.out_valid", 64'(v1), 64'd0);
    chk("rst.carry_count", 64'(n8), 64'd0);
    @(negedge clk);
    in_valid = 0;
    rst = 0;

    // Truth table on the 1-lane instance.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, tt_x[i], tt_y[i], 8'h00, 8'h00);
      chk($sformatf("tt%0d.s", i), 64'(s1), 64'(tt_s[i]));
      chk($sformatf("tt%0d.c", i), 64'(c1), 64'(tt_c[i]));
      chk($sformatf("tt%0d.count", i), 64'(n1), 64'(tt_c[i]));
      chk($sformatf("tt%0d.valid", i), 64'(v1), 64'd1);
    end

    // Hold: idle cycle keeps results, drops valid; X operands while idle change nothing.
    step(1'b1, 1'b1, 1'b1, 8'h0F, 8'h03);
    step(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF);
    chk("hold.s", 64'(s1), 64'd0);
    chk("hold.c", 64'(c1), 64'd1);
    chk("hold.valid", 64'(v1), 64'd0);
    chk("hold.c8", 64'(c8), 64'h03);
    step(1'b0, 1'bx, 1'bx, 8'hxx, 8'hxx);
    chk("holdx.c", 64'(c1), 64'd1);
    chk("holdx.count8", 64'(n8), 64'd2);

    // Vector lanes.
    step(1'b1, 1'b0, 1'b0, 8'hF0, 8'h3C);
    chk("vec1.s", 64'(s8), 64'hCC);
    chk("vec1.c", 64'(c8), 64'h30);
    chk("vec1.count", 64'(n8), 64'd2);
    chk("vec1.any", 64'(a8), 64'd1);
    step(1'b1, 1'b0, 1'b0, 8'hAA, 8'h55);
    chk("vec2.s", 64'(s8), 64'hFF);
    chk("vec2.c", 64'(c8), 64'h00);
    chk("vec2.count", 64'(n8), 64'd0);
    chk("vec2.any", 64'(a8), 64'd0);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    chk("vec3.count", 64'(n8), 64'd8);

    // Async reset mid-stream, between edges, during back-to-back traffic.
    step(1'b1, 1'b1, 1'b1, 8'hF7, 8'hFF);
    #1;
    rst = 1;
    #1;
    chk("arst.valid", 64'(v8), 64'd0);
    chk("arst.c", 64'(c8), 64'd0);
    chk("arst.count", 64'(n8), 64'd0);
    chk("arst.c1", 64'(c1), 64'd0);
    model_clear();
    #1;
    rst = 0;
    step(1'b1, 1'b1, 1'b0, 8'h81, 8'h83);
    chk("post.s", 64'(s8), 64'h02);
    chk("post.c", 64'(c8), 64'h81);
    chk("post.count", 64'(n8), 64'd2);

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom));
    end

`ifdef HA_STATS_EN
    @(negedge clk);
    rst = 1;
    #1;
    model_clear();
    rst = 0;
    step(1'b1, 1'b0, 1'b0, 8'h01, 8'h01);
    step(1'b1, 1'b0, 1'b0, 8'h01, 8'h02);
    step(1'b1, 1'b0, 1'b0, 8'h80, 8'hC0);
    step(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
    step(1'b1, 1'b0, 1'b0, 8'h0F, 8'hF0);
    step(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
    chk("stat.three", 64'(st8), 64'd3);
    @(negedge clk);
    in_valid = 0;
    force dut8.stat_q = 16'hFFFF;
    #1;
    release dut8.stat_q;
    m_stat8 = 65535;
    step(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
    chk("stat.sat", 64'(st8), 64'hFFFF);
`endif

    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/half_adder_reg.md
Name: half_adder_reg

Overview:
- Registered, vectorised half adder: WIDTH independent 1-bit half-adder lanes, with s = x XOR y and c = x AND y per lane.
- Results are captured in output registers with a valid strobe. Per-cycle carry summary outputs are also registered.
- Used as a leaf arithmetic primitive in the datapath wherever bitwise add-without-carry-in is needed with a registered timing boundary.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (legal range 1..64).
- CW, $clog2(WIDTH+1), width of carry_count (derived localparam; not overridable).

Ports:
- clk  input  1  rising-edge clock, the single clock domain.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operands on x/y are valid this cycle.
- x  input  WIDTH  operand A, one bit per lane.
- y  input  WIDTH  operand B, one bit per lane.
- out_valid  output  1  registered; s/c/summary outputs are updated this cycle.
- s  output  WIDTH  registered sum, per-lane x XOR y.
- c  output  WIDTH  registered carry, per-lane x AND y.
- carry_count  output  CW  registered number of lanes with c=1.
- any_carry  output  1  registered OR-reduction of c.
- stat_carry_ops  output  16  present only with HA_STATS_EN; see Optional Feature.

Behaviour:
- Reset: rst is asynchronous and active-high. While rst is high, all of the following are 0:
  - out_valid, s, c, carry_count, any_carry;
  - stat_carry_ops, when that feature is compiled in.
- Reset release: outputs stay 0 until the first rising clk edge with in_valid=1.
- Latency is exactly 1 cycle. On the rising clk edge with in_valid=1:
  - s <= x ^ y;
  - c <= x & y;
  - carry_count <= popcount(x & y);
  - any_carry <= |(x & y);
  - out_valid <= 1.
- On a rising edge with in_valid=0:
  - out_valid <= 0;
  - s, c, carry_count and any_carry hold their previous values.
- Back-to-back in_valid=1 is accepted every cycle. There is no backpressure and no ready signal.
- Lanes are fully independent. There is no carry propagation between lanes.
- Per-lane truth table (x,y -> s,c): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- carry_count range is 0..WIDTH. With WIDTH=1 it equals c[0].
- X/Z on x or y while in_valid=0 must not disturb the held outputs.
- If rst asserts mid-stream, the in-flight result is discarded and all outputs clear immediately, without waiting for a clock edge.
- There are no combinational paths from any input to any output.

Optional Feature:
- Macro: HA_STATS_EN.
- When defined:
  - adds output stat_carry_ops[15:0], cleared by rst;
  - it increments by 1 on each accepted operation (in_valid=1) where |(x & y)=1;
  - it saturates at 16'hFFFF and never wraps.
- When not defined:
  - the port and counter are absent;
  - all other behaviour is identical.

Test Plan:
- Reset: assert rst with x=1, y=1, in_valid=1 -> s=0, c=0, out_valid=0, carry_count=0 immediately, with no clock edge needed.
- Truth-table sweep, WIDTH=1, in_valid=1, one vector per cycle: (0,0),(0,1),(1,0),(1,1) -> one cycle later (s,c) = (0,0),(1,0),(1,0),(0,1), with out_valid=1 on each.
- Hold: apply x=1, y=1 with in_valid=1, then x=0, y=1 with in_valid=0 -> s=0, c=1 held; out_valid drops to 0 the cycle after the in_valid=0 edge.
- Vector lanes, WIDTH=8: x=8'hF0, y=8'h3C -> s=8'hCC, c=8'h30, carry_count=2, any_carry=1. Then x=8'hAA, y=8'h55 -> s=8'hFF, c=8'h00, carry_count=0, any_carry=0.
- Async reset mid-stream: pulse rst between clock edges during back-to-back valid traffic -> all outputs clear at once; the next valid operation after release produces a correct result.
- HA_STATS_EN: 3 accepted operations with a carry plus 2 without -> stat_carry_ops=3. Force the counter to 16'hFFFF and apply one more carry operation -> value stays 16'hFFFF.
